// File: rtl/ray_pkg.sv
// Shared types and float helpers for the sphere-tracing controller.
// Floats are 27 bits: [26] sign, [25:18] exponent (bias 127), [17:0] mantissa; zero exponent reads as zero.
package ray_pkg;

  localparam int FP_W = 27;
  localparam logic [26:0] FP_ZERO      = 27'h0000000;
  localparam logic [26:0] FP_ONE       = 27'h1fc0000;
  localparam logic [26:0] EPS_DEF      = 27'h1d40000;
  localparam logic [26:0] MAX_DIST_DEF = 27'h2140000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_SDF,
    ST_EVAL,
    ST_ACC,
    ST_DONE
  } state_t;

  // Truncating multiply; underflow flushes to zero, overflow clamps to the largest finite value.
  function automatic logic [26:0] fp_mul(input logic [26:0] a, input logic [26:0] b);
    logic [37:0] prod;
    logic signed [10:0] e;
    logic [17:0] m;
    prod = 38'({1'b1, a[17:0]}) * 38'({1'b1, b[17:0]});
    e = $signed({3'b000, a[25:18]}) + $signed({3'b000, b[25:18]}) - 11'sd127;
    if (prod[37]) begin
      m = prod[36:19];
      e = e + 11'sd1;
    end else begin
      m = prod[35:18];
    end
    if (a[25:18] == 8'd0 || b[25:18] == 8'd0 || e <= 11'sd0) return FP_ZERO;
    if (e >= 11'sd255) return {a[26] ^ b[26], 8'hfe, 18'h3ffff};
    return {a[26] ^ b[26], e[7:0], m};
  endfunction

  // Truncating add: align the smaller magnitude onto the larger, then renormalise.
  function automatic logic [26:0] fp_add(input logic [26:0] a, input logic [26:0] b);
    logic [26:0] big, sml;
    logic [7:0] sh;
    logic [19:0] mb, ms, sum;
    logic signed [9:0] e;
    if (a[25:0] >= b[25:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    if (sml[25:18] == 8'd0) return big;
    sh = big[25:18] - sml[25:18];
    mb = {2'b01, big[17:0]};
    ms = (sh > 8'd19) ? 20'd0 : ({2'b01, sml[17:0]} >> sh);
    e = $signed({2'b00, big[25:18]});
    if (big[26] == sml[26]) begin
      sum = mb + ms;
      if (sum[19]) begin
        sum = sum >> 1;
        e = e + 10'sd1;
      end
    end else begin
      sum = mb - ms;
      if (sum == 20'd0) return FP_ZERO;
      for (int i = 0; i < 19; i++) begin
        if (!sum[18]) begin
          sum = sum << 1;
          e = e - 10'sd1;
        end
      end
    end
    if (e <= 10'sd0) return FP_ZERO;
    if (e >= 10'sd255) return {big[26], 8'hfe, 18'h3ffff};
    return {big[26], e[7:0], sum[17:0]};
  endfunction

endpackage

// File: rtl/ray_point_gen.sv
// Sample-point generator p = o + t*d per axis, delivered after a fixed LATENCY-deep pipeline.
// Output holds the last computed point while t is stable.
module ray_point_gen
  import ray_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] t,
  input  logic [26:0] org_x,
  input  logic [26:0] org_y,
  input  logic [26:0] org_z,
  input  logic [26:0] dir_x,
  input  logic [26:0] dir_y,
  input  logic [26:0] dir_z,
  output logic [26:0] pt_x,
  output logic [26:0] pt_y,
  output logic [26:0] pt_z
);

  logic [3*FP_W-1:0] pt_comb;
  logic [3*FP_W-1:0] pipe [LATENCY];

  assign pt_comb = {fp_add(org_x, fp_mul(t, dir_x)),
                    fp_add(org_y, fp_mul(t, dir_y)),
                    fp_add(org_z, fp_mul(t, dir_z))};

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= pt_comb;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {pt_x, pt_y, pt_z} = pipe[LATENCY-1];

endmodule

// File: rtl/ray_march_ctrl.sv
// Sphere-tracing controller: marches one ray through the SDF pipeline and reports hit/miss, t and steps.
// Optional RAY_MARCH_STATS_EN adds o_cycles (accept-to-result cycle count, saturating).
//
// state | meaning
// IDLE  | ready for a new ray
// GEN   | waiting for the point generator
// SDF   | point strobed, waiting for the matching distance
// EVAL  | hit test on the captured distance
// ACC   | t += dist, escape / step-limit test
// DONE  | result held until accepted
module ray_march_ctrl
  import ray_pkg::*;
#(
  parameter int          SDF_LATENCY = 12,
  parameter int          PT_LATENCY  = 4,
  parameter int          ADD_LATENCY = 2,
  parameter int          MAX_STEPS   = 32,
  parameter int          STEP_W      = 6,
  parameter logic [26:0] EPS         = EPS_DEF,
  parameter logic [26:0] MAX_DIST    = MAX_DIST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ray_valid,
  output logic              o_ray_ready,
  input  logic [26:0]       i_org_x,
  input  logic [26:0]       i_org_y,
  input  logic [26:0]       i_org_z,
  input  logic [26:0]       i_dir_x,
  input  logic [26:0]       i_dir_y,
  input  logic [26:0]       i_dir_z,
  output logic [26:0]       o_pt_x,
  output logic [26:0]       o_pt_y,
  output logic [26:0]       o_pt_z,
  output logic              o_pt_valid,
  input  logic [26:0]       i_dist,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic              o_hit,
  output logic [26:0]       o_t,
  output logic [STEP_W-1:0] o_steps
`ifdef RAY_MARCH_STATS_EN
  ,
  output logic [31:0]       o_cycles
`endif
);

  localparam int CNT_W = $clog2(SDF_LATENCY + PT_LATENCY + ADD_LATENCY + 1);

  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic run_q;
  logic [26:0] org_x, org_y, org_z, dir_x, dir_y, dir_z;
  logic [26:0] t_q, dist_q, t_sum;
  logic [STEP_W-1:0] steps_q;
  logic hit_q, eval_hit, acc_stop;

  assign t_sum    = fp_add(t_q, dist_q);
  // Operands are non-negative here, so magnitude bits compare as unsigned integers.
  assign eval_hit = dist_q[26] || (dist_q[25:0] < EPS[25:0]);
  assign acc_stop = (t_sum[25:0] > MAX_DIST[25:0]) || (steps_q == STEP_W'(MAX_STEPS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    o_ray_ready = 1'b0;
    o_pt_valid  = 1'b0;
    o_res_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        o_ray_ready = run_q;
        if (run_q && i_ray_valid) begin
          state_n = ST_GEN;
          cnt_n   = CNT_W'(PT_LATENCY - 1);
        end
      end
      ST_GEN: begin
        if (cnt == '0) begin
          state_n = ST_SDF;
          cnt_n   = CNT_W'(SDF_LATENCY);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_SDF: begin
        o_pt_valid = (cnt == CNT_W'(SDF_LATENCY));
        if (cnt == '0) state_n = ST_EVAL;
        else           cnt_n   = cnt - 1'b1;
      end
      ST_EVAL: begin
        if (eval_hit) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_ACC;
          cnt_n   = CNT_W'(ADD_LATENCY - 1);
        end
      end
      ST_ACC: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (acc_stop) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_GEN;
          cnt_n   = CNT_W'(PT_LATENCY - 1);
        end
      end
      ST_DONE: begin
        o_res_valid = 1'b1;
        if (i_res_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q   <= 1'b0;
      {org_x, org_y, org_z, dir_x, dir_y, dir_z} <= '0;
      t_q     <= FP_ZERO;
      dist_q  <= FP_ZERO;
      steps_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (o_ray_ready && i_ray_valid) begin
        {org_x, org_y, org_z} <= {i_org_x, i_org_y, i_org_z};
        {dir_x, dir_y, dir_z} <= {i_dir_x, i_dir_y, i_dir_z};
        t_q     <= FP_ZERO;
        steps_q <= '0;
        hit_q   <= 1'b0;
      end
      if (state == ST_GEN && cnt == '0) steps_q <= steps_q + 1'b1;
      if (state == ST_SDF && cnt == '0) dist_q <= i_dist;
      if (state == ST_EVAL && eval_hit) hit_q <= 1'b1;
      if (state == ST_ACC && cnt == '0) t_q <= t_sum;
    end
  end

  ray_point_gen #(.LATENCY(PT_LATENCY)) u_point_gen (
    .clk   (clk),
    .reset (reset),
    .t     (t_q),
    .org_x (org_x),
    .org_y (org_y),
    .org_z (org_z),
    .dir_x (dir_x),
    .dir_y (dir_y),
    .dir_z (dir_z),
    .pt_x  (o_pt_x),
    .pt_y  (o_pt_y),
    .pt_z  (o_pt_z)
  );

  assign o_hit   = hit_q;
  assign o_t     = t_q;
  assign o_steps = steps_q;

`ifdef RAY_MARCH_STATS_EN
  logic [31:0] cycles_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycles_q <= '0;
    end else if (o_ray_ready && i_ray_valid) begin
      cycles_q <= '0;
    end else if (state != ST_IDLE && state != ST_DONE && cycles_q != 32'hffffffff) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end
  assign o_cycles = cycles_q;
`endif

endmodule
